// File: rtl/seg7_pkg.sv
// seg7_pkg: digit byte layout, off levels and active-low hex glyph table
package seg7_pkg;
    localparam int DIG_VAL_HI = 3;
    localparam int DIG_VAL_LO = 0;
    localparam int DIG_DP = 4;
    localparam int DIG_BLANK = 5;
    localparam logic [7:0] DIG_RESET = 8'h20;
    localparam logic [3:0] SEL_OFF = 4'hF;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: digit byte to active-low {dp,g..a} segments with blank and dp
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [7:0] dig_i,
    output logic [7:0] seg_o
);
    logic unused_bits;
    assign unused_bits = ^dig_i[7:6];
    assign seg_o = dig_i[DIG_BLANK] ? SEG_OFF
                 : {~dig_i[DIG_DP], GLYPH[dig_i[DIG_VAL_HI:DIG_VAL_LO]][6:0]};
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: 4-digit 7-segment scanner with frame-synchronous commit and dead time
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50_000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic       clk_50m,
    input  logic       sw_rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] leds_o,
    output logic [3:0] sels_o,
    output logic       frame_o
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD = CW'(DEAD_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    pending_q [4], pending_d [4];
    logic [7:0]    shadow_q [4], shadow_d [4];
    logic [7:0]    leds_q, leds_d, seg;
    logic [3:0]    sels_q, sels_d;
    logic          frame_q, frame_d, wrap, show;

    seg7_hex_decode u_dec (.dig_i(shadow_q[idx_q]), .seg_o(seg));

    // a blanked digit keeps its select off too, so it looks exactly like the gap
    always_comb begin
        wrap = cnt_q == LAST;
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        frame_d = wrap && idx_q == 2'd3;
        pending_d = pending_q;
        if (wr_en) pending_d[wr_addr] = wr_data;
        shadow_d = frame_d ? pending_q : shadow_q;
        show = cnt_q >= DEAD && !shadow_q[idx_q][DIG_BLANK];
        leds_d = show ? seg : SEG_OFF;
        sels_d = show ? ~(4'b1 << idx_q) : SEL_OFF;
    end

    always_ff @(posedge clk_50m or negedge sw_rst_n) begin
        if (!sw_rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            pending_q <= '{default: DIG_RESET};
            shadow_q <= '{default: DIG_RESET};
            leds_q <= SEG_OFF;
            sels_q <= SEL_OFF;
            frame_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            pending_q <= pending_d;
            shadow_q <= shadow_d;
            leds_q <= leds_d;
            sels_q <= sels_d;
            frame_q <= frame_d;
        end
    end

    assign leds_o = leds_q;
    assign sels_o = sels_q;
    assign frame_o = frame_q;
endmodule
